// File: rtl/aes_inv_round_ctrl.sv
// -----------------------------------------------------------------------------
// aes_inv_round_ctrl
//
// Sequencing controller for an iterative AES-128 inverse cipher. The controller
// owns the 128-bit state register and a round counter. It steps an external
// combinational inverse-round datapath through rounds 9..1 and then the final
// round, and it selects which round key is read from an external key store.
// A block is accepted only when the controller is idle, so no pipelining is
// done.
//
// Optional feature: define AES_INV_ABORT_EN to add the 'abort' input. When
// abort is high at a clock edge, the FSM returns to IDLE and the state register
// keeps its value.
//
// Ports
//   clk        in   1    clock, rising edge
//   rst        in   1    synchronous reset, active high
//   in_valid   in   1    ciphertext block offered
//   in_ready   out  1    block accepted this cycle (IDLE only)
//   in_data    in   128  ciphertext block
//   out_valid  out  1    plaintext available (DONE)
//   out_ready  in   1    consumer takes plaintext
//   out_data   out  128  plaintext, equal to the state register
//   rk_idx     out  4    round-key index requested from the key store
//   rk_in      in   128  round key for rk_idx (combinational lookup)
//   dp_state   out  128  state driven to the inverse-round datapath
//   dp_last    out  1    final round, so the datapath skips InvMixColumns
//   dp_out     in   128  datapath result
//   busy       out  1    high in every state except IDLE
//   abort      in   1    (AES_INV_ABORT_EN only) return to IDLE
//
// State   | meaning
// --------+--------------------------------------------------------------
// IDLE    | waiting for a block; rk_idx=10 for the initial AddRoundKey
// ROUND   | full inverse round using key 'round'; counts 9 down to 1
// FINAL   | last inverse round with key 0, InvMixColumns skipped
// DONE    | plaintext presented and held until out_ready
// -----------------------------------------------------------------------------
module aes_inv_round_ctrl (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic [3:0]   rk_idx,
    input  logic [127:0] rk_in,
    output logic [127:0] dp_state,
    output logic         dp_last,
    input  logic [127:0] dp_out,
    output logic         busy
`ifdef AES_INV_ABORT_EN
   ,input  logic         abort
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ROUND = 2'd1,
        S_FINAL = 2'd2,
        S_DONE  = 2'd3
    } fsm_t;

    localparam logic [3:0] RK_FIRST = 4'd10;

    fsm_t         fsm_q, fsm_d;
    logic [3:0]   round_q, round_d;
    logic [127:0] state_q, state_d;

    logic         abort_w;
    logic         accept;

`ifdef AES_INV_ABORT_EN
    assign abort_w = abort;
`else
    assign abort_w = 1'b0;
`endif

    // in_ready is masked by abort so that a block is never both accepted and
    // dropped in the same cycle.
    assign in_ready = (fsm_q == S_IDLE) && !rst && !abort_w;
    assign accept   = in_valid && in_ready;

    // The outputs come from the registered FSM state. They are also gated by
    // rst, so that they read as idle for the whole time reset is held.
    assign out_valid = (fsm_q == S_DONE)  && !rst;
    assign busy      = (fsm_q != S_IDLE)  && !rst;
    assign dp_last   = (fsm_q == S_FINAL) && !rst;
    assign out_data  = state_q;
    assign dp_state  = state_q;

    always_comb begin
        rk_idx = RK_FIRST;
        if (!rst) begin
            case (fsm_q)
                S_ROUND: rk_idx = round_q;
                S_FINAL: rk_idx = 4'd0;
                default: rk_idx = RK_FIRST;
            endcase
        end
    end

    always_comb begin
        fsm_d   = fsm_q;
        round_d = round_q;
        state_d = state_q;
        case (fsm_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = in_data ^ rk_in;
                    round_d = 4'd9;
                    fsm_d   = S_ROUND;
                end
            end
            S_ROUND: begin
                state_d = dp_out;
                if (round_q == 4'd1) begin
                    fsm_d = S_FINAL;
                end else begin
                    round_d = round_q - 4'd1;
                end
            end
            S_FINAL: begin
                state_d = dp_out;
                fsm_d   = S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
                    fsm_d = S_IDLE;
                end
            end
            default: fsm_d = S_IDLE;
        endcase
        // Abort drops the block in flight but leaves the state register as it
        // is, so a partly processed value stays visible on out_data.
        if (abort_w) begin
            fsm_d   = S_IDLE;
            round_d = round_q;
            state_d = state_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q   <= S_IDLE;
            round_q <= 4'd0;
            state_q <= 128'd0;
        end else begin
            fsm_q   <= fsm_d;
            round_q <= round_d;
            state_q <= state_d;
        end
    end

endmodule

// File: tb/tb_aes_inv_round_ctrl.sv
// -----------------------------------------------------------------------------
// tb_aes_inv_round_ctrl
//
// Bench for aes_inv_round_ctrl. The bench models the key store and the inverse
// round datapath. Each accepted block puts its expected plaintext, computed with
// a complete AES-128 inverse cipher, into a scoreboard queue. A separate monitor
// takes entries from that queue when output handshakes happen. The monitor also
// checks the latency from acceptance to out_valid.
// -----------------------------------------------------------------------------
module tb_aes_inv_round_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic [3:0]   rk_idx;
    logic [127:0] rk_in;
    logic [127:0] dp_state;
    logic         dp_last;
    logic [127:0] dp_out;
    logic         busy;
`ifdef AES_INV_ABORT_EN
    logic         abort;
`endif

    always #5 clk = ~clk;

    aes_inv_round_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .rk_idx    (rk_idx),
        .rk_in     (rk_in),
        .dp_state  (dp_state),
        .dp_last   (dp_last),
        .dp_out    (dp_out),
        .busy      (busy)
`ifdef AES_INV_ABORT_EN
       ,.abort     (abort)
`endif
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last_acc = 0;
    int rdy_mode = 1;   // 0: hold low, 1: hold high, 2: random

    typedef struct {
        logic [127:0] data;
        int           acc;
    } exp_t;
    exp_t sb[$];

    logic [127:0] rkeys [0:10];

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- AES helpers ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        logic       hi;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            hi = x[7];
            x  = {x[6:0], 1'b0};
            if (hi) x = x ^ 8'h1b;
            y = {1'b0, y[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        if (a == 8'h00) return 8'h00;
        for (int x = 1; x < 256; x++)
            if (gmul(a, 8'(x)) == 8'h01) return 8'(x);
        return 8'h00;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [15:0] t = {x, x};
        return t[15-n -: 8];
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [7:0] g = gf_inv(b);
        return g ^ rotl8(g, 1) ^ rotl8(g, 2) ^ rotl8(g, 3) ^ rotl8(g, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        logic [7:0] t = rotl8(s, 1) ^ rotl8(s, 3) ^ rotl8(s, 6) ^ 8'h05;
        return gf_inv(t);
    endfunction

    // One inverse round in FIPS-197 InvCipher order: InvShiftRows, InvSubBytes,
    // AddRoundKey, then InvMixColumns unless this is the last round.
    function automatic logic [127:0] inv_round(input logic [127:0] st,
                                               input logic [127:0] rk,
                                               input logic last);
        logic [7:0]   a [16];
        logic [7:0]   b [16];
        logic [7:0]   c0, c1, c2, c3;
        logic [127:0] r;
        for (int i = 0; i < 16; i++) a[i] = st[127-8*i -: 8];
        for (int c = 0; c < 4; c++)
            for (int rr = 0; rr < 4; rr++)
                b[rr+4*c] = inv_sbox(a[rr + 4*((c - rr + 4) % 4)]) ^ rk[127-8*(rr+4*c) -: 8];
        if (!last) begin
            for (int c = 0; c < 4; c++) begin
                c0 = b[4*c]; c1 = b[4*c+1]; c2 = b[4*c+2]; c3 = b[4*c+3];
                b[4*c]   = gmul(c0,8'h0e) ^ gmul(c1,8'h0b) ^ gmul(c2,8'h0d) ^ gmul(c3,8'h09);
                b[4*c+1] = gmul(c0,8'h09) ^ gmul(c1,8'h0e) ^ gmul(c2,8'h0b) ^ gmul(c3,8'h0d);
                b[4*c+2] = gmul(c0,8'h0d) ^ gmul(c1,8'h09) ^ gmul(c2,8'h0e) ^ gmul(c3,8'h0b);
                b[4*c+3] = gmul(c0,8'h0b) ^ gmul(c1,8'h0d) ^ gmul(c2,8'h09) ^ gmul(c3,8'h0e);
            end
        end
        for (int i = 0; i < 16; i++) r[127-8*i -: 8] = b[i];
        return r;
    endfunction

    task automatic set_key(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rcon = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])};
                t[31:24] = t[31:24] ^ rcon;
                rcon = gmul(rcon, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) rkeys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [127:0] aes_decrypt(input logic [127:0] ct);
        logic [127:0] s = ct ^ rkeys[10];
        for (int r = 9; r >= 1; r--) s = inv_round(s, rkeys[r], 1'b0);
        return inv_round(s, rkeys[0], 1'b1);
    endfunction

    // The key store and datapath models. Their inputs change only at or just
    // after a rising edge, so evaluating them on the falling edge keeps
    // rk_in and dp_out stable before the next rising edge.
    initial begin
        rk_in  = '0;
        dp_out = '0;
        forever begin
            @(negedge clk);
            if (rk_idx <= 4'd10) begin
                rk_in  = rkeys[rk_idx];
                dp_out = inv_round(dp_state, rkeys[rk_idx], dp_last);
            end else begin
                rk_in  = '0;
                dp_out = '0;
            end
        end
    end

    // ---------------- out_ready driver ----------------
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       out_ready = 1'b0;
                1:       out_ready = 1'b1;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // ---------------- check helpers ----------------
    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // ---------------- monitor ----------------
    initial begin
        logic ov_prev = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (out_valid && !ov_prev) begin
                    if (sb.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_out_valid: got out_valid=1 required no output (cycle %0d)", cyc);
                    end else begin
                        check_int("latency", cyc - sb[0].acc, 11);
                    end
                end
                if (out_valid && out_ready && sb.size() > 0) begin
                    e = sb.pop_front();
                    check("out_data", out_data, e.data);
                end
            end
            ov_prev = out_valid;
        end
    end

    // ---------------- stimulus ----------------
    task automatic send(input logic [127:0] blk, input bit keep);
        int n = 0;
        in_data  = blk;
        in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 100) begin
                total++;
                bad++;
                $display("FAIL accept_timeout: got no in_ready required acceptance within 100 cycles");
                in_valid = 1'b0;
                return;
            end
        end
        sb.push_back('{data: aes_decrypt(blk), acc: cyc});
        last_acc = cyc;
        @(posedge clk);
        #1;
        if (!keep) in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (sb.size() != 0 || busy) begin
            @(negedge clk);
            n++;
            if (n > 300) begin
                total++;
                bad++;
                $display("FAIL idle_timeout: got busy=%0b pending=%0d required idle", busy, sb.size());
                sb.delete();
                break;
            end
        end
    endtask

    task automatic wait_out_valid();
        int n = 0;
        while (!out_valid) begin
            @(negedge clk);
            n++;
            if (n > 50) begin
                total++;
                bad++;
                $display("FAIL out_valid_timeout: got out_valid=0 required 1");
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish required finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [127:0] snap;
        logic [127:0] blk;
        int           a1;
        int           seen;

        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
`ifdef AES_INV_ABORT_EN
        abort    = 1'b0;
`endif
        for (int r = 0; r < 11; r++) rkeys[r] = '0;

        // Outputs while reset is held.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready",  128'(in_ready),  128'd0);
        check("rst_out_valid", 128'(out_valid), 128'd0);
        check("rst_busy",      128'(busy),      128'd0);
        check("rst_rk_idx",    128'(rk_idx),    128'd10);
        check("rst_dp_last",   128'(dp_last),   128'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("post_rst_state",    out_data,        128'd0);
        check("post_rst_in_ready", 128'(in_ready),  128'd1);
        check("post_rst_busy",     128'(busy),      128'd0);

        // FIPS-197 C.1 known answer, with a trace of rk_idx and dp_last.
        set_key(128'h000102030405060708090a0b0c0d0e0f);
        check("fips_model", aes_decrypt(128'h69c4e0d86a7b0430d8cdb78070b4c55a),
              128'h00112233445566778899aabbccddeeff);
        @(posedge clk);
        #1;
        in_data  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        in_valid = 1'b1;
        @(negedge clk);
        check("fips_in_ready", 128'(in_ready), 128'd1);
        sb.push_back('{data: aes_decrypt(in_data), acc: cyc});
        check("trace_rk_10", 128'(rk_idx), 128'd10);
        @(posedge clk);
        #1 in_valid = 1'b0;
        for (int k = 9; k >= 0; k--) begin
            @(negedge clk);
            check($sformatf("trace_rk_%0d", k), 128'(rk_idx), 128'(k));
            check($sformatf("trace_last_%0d", k), 128'(dp_last), 128'(k == 0));
            check("trace_in_ready", 128'(in_ready), 128'd0);
        end
        @(negedge clk);
        check("fips_out_valid", 128'(out_valid), 128'd1);
        check("fips_out_data",  out_data, 128'h00112233445566778899aabbccddeeff);
        check("done_rk_idx",    128'(rk_idx), 128'd10);
        wait_idle();

        // Output held back for 5 cycles in DONE; in_valid must be ignored.
        rdy_mode = 0;
        @(posedge clk);
        #1;
        send({$urandom, $urandom, $urandom, $urandom}, 1'b0);
        wait_out_valid();
        snap     = out_data;
        in_valid = 1'b1;
        in_data  = {$urandom, $urandom, $urandom, $urandom};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_out_valid", 128'(out_valid), 128'd1);
            check("hold_out_data",  out_data, snap);
            check("hold_in_ready",  128'(in_ready), 128'd0);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        rdy_mode = 1;
        wait_idle();

        // Two blocks with in_valid held high throughout.
        set_key({$urandom, $urandom, $urandom, $urandom});
        @(posedge clk);
        #1;
        send({$urandom, $urandom, $urandom, $urandom}, 1'b1);
        a1 = last_acc;
        send({$urandom, $urandom, $urandom, $urandom}, 1'b0);
        check_int("b2b_spacing", last_acc - a1, 12);
        wait_idle();

        // Random keys and blocks with a randomly stalling consumer.
        rdy_mode = 2;
        for (int it = 0; it < 8; it++) begin
            set_key({$urandom, $urandom, $urandom, $urandom});
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
            send({$urandom, $urandom, $urandom, $urandom}, 1'b0);
            wait_idle();
        end
        rdy_mode = 1;
        @(posedge clk);

        // Reset in the middle of a block; the block must not come out.
        #1;
        send({$urandom, $urandom, $urandom, $urandom}, 1'b0);
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        sb.delete();
        @(negedge clk);
        check("midrst_busy",     128'(busy),     128'd0);
        check("midrst_in_ready", 128'(in_ready), 128'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("after_rst_busy",     128'(busy),     128'd1 - 128'd1);
        check("after_rst_in_ready", 128'(in_ready), 128'd1);
        check("after_rst_state",    out_data,       128'd0);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check_int("no_out_after_rst", seen, 0);

`ifdef AES_INV_ABORT_EN
        // Abort in the third ROUND cycle, then a new block decrypts correctly.
        @(posedge clk);
        #1;
        send({$urandom, $urandom, $urandom, $urandom}, 1'b0);
        repeat (2) @(posedge clk);
        #1 abort = 1'b1;
        @(negedge clk);
        snap = out_data;
        @(posedge clk);
        #1 abort = 1'b0;
        sb.delete();
        @(negedge clk);
        check("abort_busy",     128'(busy),     128'd0);
        check("abort_in_ready", 128'(in_ready), 128'd1);
        check("abort_state",    out_data,       snap);
        // Abort in IDLE blocks acceptance.
        @(posedge clk);
        #1;
        abort    = 1'b1;
        in_valid = 1'b1;
        in_data  = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
        check("abort_idle_in_ready", 128'(in_ready), 128'd0);
        @(posedge clk);
        #1;
        abort    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("abort_idle_busy", 128'(busy), 128'd0);
        @(posedge clk);
        #1;
        send({$urandom, $urandom, $urandom, $urandom}, 1'b0);
        wait_idle();
`endif

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/aes_inv_round_ctrl.md
AES_INV_ROUND_CTRL -- requirements
Module: aes_inv_round_ctrl

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have port: in_valid  input  1  ciphertext block offered.
REQ-004 SHALL have port: in_ready  output  1  controller accepts a block this cycle.
REQ-005 SHALL have port: in_data  input  128  ciphertext block.
REQ-006 SHALL have port: out_valid  output  1  plaintext block available.
REQ-007 SHALL have port: out_ready  input  1  consumer accepts plaintext.
REQ-008 SHALL have port: out_data  output  128  plaintext block; equals the state register.
REQ-009 SHALL have port: rk_idx  output  4  round-key index requested from the key store.
REQ-010 SHALL have port: rk_in  input  128  round key for rk_idx, valid in the same cycle (combinational lookup).
REQ-011 SHALL have port: dp_state  output  128  state fed to the external inverse-round datapath.
REQ-012 SHALL have port: dp_last  output  1  datapath omits InvMixColumns (final round).
REQ-013 SHALL have port: dp_out  input  128  combinational datapath result: InvShiftRows, InvSubBytes, AddRoundKey(rk_in), then InvMixColumns unless dp_last.
REQ-014 SHALL have port: busy  output  1  high in every state except IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, ROUND, FINAL and DONE, plus a 4-bit round counter and a 128-bit state register.
REQ-016 IDLE: in_ready=1, rk_idx=10; on in_valid&&in_ready, state <= in_data ^ rk_in, round <= 9, go to ROUND.
REQ-017 ROUND: rk_idx=round, dp_last=0, state <= dp_out; if round==1 go to FINAL, else round <= round-1 and stay in ROUND.
REQ-018 FINAL: rk_idx=0, dp_last=1, state <= dp_out, go to DONE.
REQ-019 DONE: out_valid=1; state SHALL hold while out_ready=0; on out_ready, go to IDLE.
REQ-020 dp_state SHALL equal the state register in all states; dp_last SHALL be 0 outside FINAL.
REQ-021 in_ready SHALL be 0 outside IDLE; blocks SHALL NOT be accepted while busy (no pipelining, no back-to-back bypass).
REQ-022 Latency: with acceptance on edge T, ROUND updates on edges T+1..T+9, FINAL on edge T+10, out_valid high from the cycle after edge T+10.
REQ-023 Throughput: at most one block per 12 cycles when out_ready is held at 1.
REQ-024 Output handshake SHALL complete in DONE with in_ready low; in_ready SHALL rise on the next cycle.
REQ-025 rk_idx SHALL equal 10 in DONE and IDLE.

Reset
REQ-026 While rst=1 at a rising edge: FSM <= IDLE, round <= 0, state <= 0.
REQ-027 While rst is asserted, in_ready, out_valid and busy SHALL be 0; rk_idx SHALL be 10; dp_last SHALL be 0.
REQ-028 Reset mid-operation SHALL discard the block in flight; no out_valid SHALL follow for that block.

Configuration
REQ-029 With AES_INV_ABORT_EN defined: add port abort (input, 1).
REQ-030 With AES_INV_ABORT_EN defined: abort=1 at an edge forces FSM <= IDLE and out_valid low from the next cycle, with the state register unchanged.
REQ-031 With AES_INV_ABORT_EN defined: rst has priority over abort; abort in IDLE SHALL block acceptance that cycle.
REQ-032 Without AES_INV_ABORT_EN: the abort port is absent and behaviour is as in REQ-015..REQ-028.

Verification
REQ-033 FIPS-197 C.1 vector: key 000102030405060708090a0b0c0d0e0f, in_data 69c4e0d86a7b0430d8cdb78070b4c55a -> out_data 00112233445566778899aabbccddeeff, out_valid 11 cycles after acceptance.
REQ-034 Hold out_ready=0 for 5 cycles in DONE -> out_valid and out_data stable, in_ready=0, in_valid ignored.
REQ-035 in_valid held high continuously with out_ready=1, two blocks -> second block accepted exactly 12 cycles after the first; both results correct.
REQ-036 Trace rk_idx from acceptance -> sequence 10,9,8,...,1,0 with dp_last=1 only on index 0.
REQ-037 rst pulsed at cycle 5 after acceptance -> busy=0 and in_ready=1 after reset; no out_valid for the aborted block.
REQ-038 With AES_INV_ABORT_EN: abort in cycle 3 of ROUND -> IDLE next cycle, then a new block decrypts correctly.
